// File: rtl/pixel_mask_stage.sv
// Pixel masking stage: raster-continuity check, per-frame mode select, 2-entry output buffer.
// Optional `define MASK_STATS_EN adds the per-frame replaced-pixel counter behind o_masked_total.
module pixel_mask_stage #(
    parameter logic [8:0]  LAST_COL   = 9'd319,
    parameter logic [7:0]  LAST_ROW   = 8'd239,
    parameter logic [11:0] FILL_COLOR = 12'h000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [11:0] i_pixel_in,
    input  logic [7:0]  i_pix_row,
    input  logic [8:0]  i_pix_col,
    input  logic        i_mask_bit,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [1:0]  i_mode,
    output logic [11:0] o_pixel_out,
    output logic [7:0]  o_out_row,
    output logic [8:0]  o_out_col,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic        o_frame_end,
    output logic        o_sync_error,
    output logic [16:0] o_masked_total
);

    localparam logic [0:0] ST_SYNC = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]  r_state;
    logic [1:0]  r_active_mode;
    logic [7:0]  r_exp_row;
    logic [8:0]  r_exp_col;
    logic        r_started;
    logic        r_sync_error;
    logic [1:0]  r_count;
    logic [11:0] r_head_pix;
    logic [7:0]  r_head_row;
    logic [8:0]  r_head_col;
    logic        r_head_fe;
    logic [11:0] r_skid_pix;
    logic [7:0]  r_skid_row;
    logic [8:0]  r_skid_col;
    logic        r_skid_fe;

    logic        w_accept;
    logic        w_origin;
    logic        w_match;
    logic        w_in_run;
    logic        w_mismatch;
    logic        w_push;
    logic        w_pop;
    logic        w_last;
    logic [1:0]  w_eff_mode;
    logic [11:0] w_proc_pix;
    logic [7:0]  w_next_row;
    logic [8:0]  w_next_col;

    assign o_in_ready  = r_started && (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);
    assign w_pop       = o_out_valid && i_out_ready;
    assign w_accept    = i_in_valid && o_in_ready;
    assign w_origin    = (i_pix_row == 8'd0) && (i_pix_col == 9'd0);
    assign w_match     = (i_pix_row == r_exp_row) && (i_pix_col == r_exp_col);
    assign w_in_run    = (r_state == ST_RUN);
    assign w_mismatch  = w_accept && w_in_run && !w_match;
    // A (0,0) beat always starts a frame, even when it arrives as a discontinuity.
    assign w_push      = w_accept && (w_origin || (w_in_run && w_match));
    assign w_last      = (i_pix_row == LAST_ROW) && (i_pix_col == LAST_COL);
    assign w_eff_mode  = (w_push && w_origin) ? i_mode : r_active_mode;

    assign w_next_col  = (i_pix_col == LAST_COL) ? 9'd0 : i_pix_col + 9'd1;
    assign w_next_row  = (i_pix_col != LAST_COL) ? i_pix_row :
                         (i_pix_row == LAST_ROW) ? 8'd0 : i_pix_row + 8'd1;

    always_comb begin
        w_proc_pix = i_pixel_in;
        case (w_eff_mode)
            2'b01: if (!i_mask_bit) w_proc_pix = FILL_COLOR;
            2'b10: if (!i_mask_bit) w_proc_pix = {1'b0, i_pixel_in[11:9], 1'b0, i_pixel_in[7:5],
                                                  1'b0, i_pixel_in[3:1]};
            2'b11: if (i_mask_bit)  w_proc_pix = FILL_COLOR;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= ST_SYNC;
            r_active_mode <= 2'b00;
            r_exp_row     <= 8'd0;
            r_exp_col     <= 9'd0;
            r_started     <= 1'b0;
            r_sync_error  <= 1'b0;
        end else begin
            r_started    <= 1'b1;
            r_sync_error <= w_mismatch;
            if (w_push) begin
                r_state   <= ST_RUN;
                r_exp_row <= w_next_row;
                r_exp_col <= w_next_col;
                if (w_origin) r_active_mode <= i_mode;
            end else if (w_mismatch) begin
                r_state <= ST_SYNC;
            end
        end
    end

    // Head register drives the outputs; the skid entry only fills while the head is stalled.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count    <= 2'd0;
            r_head_pix <= 12'd0;
            r_head_row <= 8'd0;
            r_head_col <= 9'd0;
            r_head_fe  <= 1'b0;
            r_skid_pix <= 12'd0;
            r_skid_row <= 8'd0;
            r_skid_col <= 9'd0;
            r_skid_fe  <= 1'b0;
        end else begin
            case (r_count)
                2'd0: begin
                    if (w_push) begin
                        r_head_pix <= w_proc_pix;
                        r_head_row <= i_pix_row;
                        r_head_col <= i_pix_col;
                        r_head_fe  <= w_last;
                        r_count    <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_push && w_pop) begin
                        r_head_pix <= w_proc_pix;
                        r_head_row <= i_pix_row;
                        r_head_col <= i_pix_col;
                        r_head_fe  <= w_last;
                    end else if (w_push) begin
                        r_skid_pix <= w_proc_pix;
                        r_skid_row <= i_pix_row;
                        r_skid_col <= i_pix_col;
                        r_skid_fe  <= w_last;
                        r_count    <= 2'd2;
                    end else if (w_pop) begin
                        r_count <= 2'd0;
                    end
                end
                default: begin
                    if (w_pop) begin
                        r_head_pix <= r_skid_pix;
                        r_head_row <= r_skid_row;
                        r_head_col <= r_skid_col;
                        r_head_fe  <= r_skid_fe;
                        r_count    <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_pixel_out  = r_head_pix;
    assign o_out_row    = r_head_row;
    assign o_out_col    = r_head_col;
    assign o_frame_end  = r_head_fe;
    assign o_sync_error = r_sync_error;

`ifdef MASK_STATS_EN
    logic [16:0] r_frame_cnt;
    logic [16:0] r_masked_total;
    logic        w_replace;
    logic [16:0] w_cnt_base;
    logic [16:0] w_cnt_next;

    // Replacement is decided by the selection, not by whether the colour actually changed.
    assign w_replace  = (w_eff_mode != 2'b00) && (i_mask_bit == (w_eff_mode == 2'b11));
    assign w_cnt_base = w_mismatch ? 17'd0 : r_frame_cnt;
    assign w_cnt_next = w_cnt_base + {16'd0, w_replace};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_frame_cnt    <= 17'd0;
            r_masked_total <= 17'd0;
        end else if (w_push && w_last) begin
            r_masked_total <= w_cnt_next;
            r_frame_cnt    <= 17'd0;
        end else if (w_push) begin
            r_frame_cnt <= w_cnt_next;
        end else begin
            r_frame_cnt <= w_cnt_base;
        end
    end

    assign o_masked_total = r_masked_total;
`else
    assign o_masked_total = 17'd0;
`endif

endmodule

// File: tb/tb_pixel_mask_stage.sv
// Directed testbench for pixel_mask_stage on a reduced 16x6 raster.
// Expected masked_total depends on whether MASK_STATS_EN is defined.
module tb_pixel_mask_stage;

    localparam logic [8:0]  LAST_COL   = 9'd15;
    localparam logic [7:0]  LAST_ROW   = 8'd5;
    localparam logic [11:0] FILL_COLOR = 12'h000;
    localparam int          COLS       = 16;
    localparam int          FRAME_PIX  = 96;

    typedef struct packed {
        logic [7:0]  row;
        logic [8:0]  col;
        logic [11:0] pix;
        logic        mask;
        logic [1:0]  mode;
    } beat_t;

    typedef struct packed {
        logic        valid;
        logic [11:0] pix;
        logic [7:0]  row;
        logic [8:0]  col;
        logic        fe;
        logic        err;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] i_pixel_in = '0;
    logic [7:0]  i_pix_row = '0;
    logic [8:0]  i_pix_col = '0;
    logic        i_mask_bit = 1'b0;
    logic        i_in_valid = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    logic        i_out_ready = 1'b1;
    logic        o_in_ready;
    logic [11:0] o_pixel_out;
    logic [7:0]  o_out_row;
    logic [8:0]  o_out_col;
    logic        o_out_valid;
    logic        o_frame_end;
    logic        o_sync_error;
    logic [16:0] o_masked_total;

    int vectors = 0;
    int miscompares = 0;

    beat_t q_in[$];
    obs_t  q_exp[$];
    obs_t  q_obs[$];

    pixel_mask_stage #(
        .LAST_COL(LAST_COL),
        .LAST_ROW(LAST_ROW),
        .FILL_COLOR(FILL_COLOR)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_pixel_in(i_pixel_in),
        .i_pix_row(i_pix_row),
        .i_pix_col(i_pix_col),
        .i_mask_bit(i_mask_bit),
        .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready),
        .i_mode(i_mode),
        .o_pixel_out(o_pixel_out),
        .o_out_row(o_out_row),
        .o_out_col(o_out_col),
        .o_out_valid(o_out_valid),
        .i_out_ready(i_out_ready),
        .o_frame_end(o_frame_end),
        .o_sync_error(o_sync_error),
        .o_masked_total(o_masked_total)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] pix_of(input int r, input int c);
        logic [11:0] v;
        v = {r[3:0], c[7:0]};
        return v ^ 12'h800;
    endfunction

    // Queue one input beat and the output it should produce one cycle later.
    task automatic add_beat(input int r, input int c, input logic [11:0] p, input logic m,
                            input logic [1:0] md, input logic ev, input logic [11:0] ep,
                            input logic ee);
        beat_t b;
        obs_t  e;
        b.row = r[7:0];
        b.col = c[8:0];
        b.pix = p;
        b.mask = m;
        b.mode = md;
        e.valid = ev;
        e.pix = ep;
        e.row = r[7:0];
        e.col = c[8:0];
        e.fe = ev && (r == int'(LAST_ROW)) && (c == int'(LAST_COL));
        e.err = ee;
        q_in.push_back(b);
        q_exp.push_back(e);
    endtask

    // Drives q_in one beat per cycle with the sink always ready and records what comes out.
    task automatic stream_beats();
        obs_t o;
        q_obs.delete();
        i_out_ready = 1'b1;
        for (int i = 0; i <= q_in.size(); i++) begin
            @(negedge clk);
            if (i > 0) begin
                o.valid = o_out_valid;
                o.pix = o_pixel_out;
                o.row = o_out_row;
                o.col = o_out_col;
                o.fe = o_frame_end;
                o.err = o_sync_error;
                q_obs.push_back(o);
            end
            if (i < q_in.size()) begin
                i_pixel_in = q_in[i].pix;
                i_pix_row = q_in[i].row;
                i_pix_col = q_in[i].col;
                i_mask_bit = q_in[i].mask;
                i_mode = q_in[i].mode;
                i_in_valid = 1'b1;
            end else begin
                i_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_in_ready, o_out_valid, o_pixel_out, o_out_row, o_out_col, o_frame_end,
             o_sync_error, o_masked_total} !== 50'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got rdy=%b vld=%b pix=%h row=%0d col=%0d fe=%b err=%b tot=%0d, expected all 0",
                     o_in_ready, o_out_valid, o_pixel_out, o_out_row, o_out_col, o_frame_end,
                     o_sync_error, o_masked_total);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({o_in_ready, o_out_valid} !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL reset_release: got rdy=%b vld=%b, expected rdy=1 vld=0",
                     o_in_ready, o_out_valid);
        end
    endtask

    task automatic test_bypass_frame();
        q_in.delete();
        q_exp.delete();
        for (int i = 0; i < FRAME_PIX; i++)
            add_beat(i / COLS, i % COLS, pix_of(i / COLS, i % COLS), 1'b0, 2'b00, 1'b1,
                     pix_of(i / COLS, i % COLS), 1'b0);
        stream_beats();
        for (int i = 0; i < q_exp.size(); i++) begin
            vectors++;
            if (q_exp[i].valid ? (q_obs[i] !== q_exp[i])
                               : ({q_obs[i].valid, q_obs[i].err} !== {1'b0, q_exp[i].err})) begin
                miscompares++;
                $display("[TB] FAIL bypass beat %0d: got %h expected %h", i, q_obs[i], q_exp[i]);
            end
        end
        vectors++;
        if (o_masked_total !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL bypass_total: got %0d expected 0", o_masked_total);
        end
    endtask

    task automatic test_fill_frame();
        logic [16:0] exp_total;
`ifdef MASK_STATS_EN
        exp_total = 17'd60;
`else
        exp_total = 17'd0;
`endif
        q_in.delete();
        q_exp.delete();
        for (int i = 0; i < FRAME_PIX; i++)
            add_beat(i / COLS, i % COLS, pix_of(i / COLS, i % COLS), (i % COLS) >= 10, 2'b01,
                     1'b1, ((i % COLS) < 10) ? 12'h000 : pix_of(i / COLS, i % COLS), 1'b0);
        stream_beats();
        for (int i = 0; i < q_exp.size(); i++) begin
            vectors++;
            if (q_exp[i].valid ? (q_obs[i] !== q_exp[i])
                               : ({q_obs[i].valid, q_obs[i].err} !== {1'b0, q_exp[i].err})) begin
                miscompares++;
                $display("[TB] FAIL fill beat %0d: got %h expected %h", i, q_obs[i], q_exp[i]);
            end
        end
        vectors++;
        if (o_masked_total !== exp_total) begin
            miscompares++;
            $display("[TB] FAIL fill_total: got %0d expected %0d", o_masked_total, exp_total);
        end
    endtask

    task automatic test_dim();
        q_in.delete();
        q_exp.delete();
        add_beat(0, 0, 12'hFA6, 1'b0, 2'b10, 1'b1, 12'h753, 1'b0);
        add_beat(0, 1, 12'hFA6, 1'b1, 2'b10, 1'b1, 12'hFA6, 1'b0);
        add_beat(0, 2, 12'h111, 1'b0, 2'b10, 1'b1, 12'h000, 1'b0);
        add_beat(0, 3, 12'h888, 1'b0, 2'b10, 1'b1, 12'h444, 1'b0);
        stream_beats();
        for (int i = 0; i < q_exp.size(); i++) begin
            vectors++;
            if (q_exp[i].valid ? (q_obs[i] !== q_exp[i])
                               : ({q_obs[i].valid, q_obs[i].err} !== {1'b0, q_exp[i].err})) begin
                miscompares++;
                $display("[TB] FAIL dim beat %0d: got %h expected %h", i, q_obs[i], q_exp[i]);
            end
        end
    endtask

    // Sink stalls for five cycles while the source keeps offering (0,4)..(0,7).
    task automatic test_back_to_back();
        int sent = 0;
        int got = 0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            @(negedge clk);
            i_out_ready = (cyc >= 5);
            if (cyc >= 1 && cyc <= 4) begin
                vectors++;
                if ({o_out_valid, o_pixel_out, o_out_row, o_out_col} !==
                    {1'b1, pix_of(0, 4), 8'd0, 9'd4}) begin
                    miscompares++;
                    $display("[TB] FAIL stall_hold cyc %0d: got vld=%b pix=%h (%0d,%0d) expected vld=1 pix=%h (0,4)",
                             cyc, o_out_valid, o_pixel_out, o_out_row, o_out_col, pix_of(0, 4));
                end
            end
            if (cyc >= 2 && cyc <= 4) begin
                vectors++;
                if (o_in_ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL stall_ready cyc %0d: got %b expected 0", cyc, o_in_ready);
                end
            end
            if (o_out_valid && i_out_ready) begin
                vectors++;
                if ({o_pixel_out, o_out_row, o_out_col} !== {pix_of(0, 4 + got), 8'd0, 9'(4 + got)}) begin
                    miscompares++;
                    $display("[TB] FAIL drain %0d: got pix=%h (%0d,%0d) expected pix=%h (0,%0d)",
                             got, o_pixel_out, o_out_row, o_out_col, pix_of(0, 4 + got), 4 + got);
                end
                got++;
            end
            if (sent < 4) begin
                i_pixel_in = pix_of(0, 4 + sent);
                i_pix_row = 8'd0;
                i_pix_col = 9'(4 + sent);
                i_mask_bit = 1'b1;
                i_in_valid = 1'b1;
                if (o_in_ready) sent++;
            end else begin
                i_in_valid = 1'b0;
            end
        end
        vectors++;
        if (got != 4) begin
            miscompares++;
            $display("[TB] FAIL drain_count: got %0d beats expected 4", got);
        end
        i_in_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if (o_out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL drain_empty: got vld=%b expected 0", o_out_valid);
        end
    endtask

    task automatic test_sync_error();
        q_in.delete();
        q_exp.delete();
        for (int i = 8; i <= 5 * COLS + 7; i++)
            add_beat(i / COLS, i % COLS, pix_of(i / COLS, i % COLS), 1'b1, 2'b10, 1'b1,
                     pix_of(i / COLS, i % COLS), 1'b0);
        add_beat(5, 9, pix_of(5, 9), 1'b1, 2'b10, 1'b0, 12'h000, 1'b1);
        add_beat(5, 10, pix_of(5, 10), 1'b1, 2'b10, 1'b0, 12'h000, 1'b0);
        add_beat(1, 0, pix_of(1, 0), 1'b1, 2'b10, 1'b0, 12'h000, 1'b0);
        add_beat(0, 0, 12'hFA6, 1'b0, 2'b00, 1'b1, 12'hFA6, 1'b0);
        add_beat(0, 1, pix_of(0, 1), 1'b0, 2'b00, 1'b1, pix_of(0, 1), 1'b0);
        stream_beats();
        for (int i = 0; i < q_exp.size(); i++) begin
            vectors++;
            if (q_exp[i].valid ? (q_obs[i] !== q_exp[i])
                               : ({q_obs[i].valid, q_obs[i].err} !== {1'b0, q_exp[i].err})) begin
                miscompares++;
                $display("[TB] FAIL sync beat %0d: got %h expected %h", i, q_obs[i], q_exp[i]);
            end
        end
    endtask

    task automatic test_mode_change();
        q_in.delete();
        q_exp.delete();
        for (int i = 2; i < FRAME_PIX; i++)
            add_beat(i / COLS, i % COLS, pix_of(i / COLS, i % COLS), 1'b0, 2'b01, 1'b1,
                     pix_of(i / COLS, i % COLS), 1'b0);
        add_beat(0, 0, pix_of(0, 0), 1'b0, 2'b01, 1'b1, 12'h000, 1'b0);
        add_beat(0, 1, pix_of(0, 1), 1'b0, 2'b01, 1'b1, 12'h000, 1'b0);
        add_beat(0, 0, pix_of(0, 0), 1'b1, 2'b11, 1'b1, 12'h000, 1'b1);
        add_beat(0, 1, pix_of(0, 1), 1'b0, 2'b11, 1'b1, pix_of(0, 1), 1'b0);
        add_beat(0, 2, pix_of(0, 2), 1'b1, 2'b11, 1'b1, 12'h000, 1'b0);
        stream_beats();
        for (int i = 0; i < q_exp.size(); i++) begin
            vectors++;
            if (q_exp[i].valid ? (q_obs[i] !== q_exp[i])
                               : ({q_obs[i].valid, q_obs[i].err} !== {1'b0, q_exp[i].err})) begin
                miscompares++;
                $display("[TB] FAIL mode_change beat %0d: got %h expected %h", i, q_obs[i], q_exp[i]);
            end
        end
        vectors++;
        if (o_masked_total !== 17'd0) begin
            miscompares++;
            $display("[TB] FAIL mode_change_total: got %0d expected 0", o_masked_total);
        end
    endtask

    task automatic test_reset_midframe();
        @(negedge clk);
        i_out_ready = 1'b0;
        i_pixel_in = pix_of(0, 3);
        i_pix_row = 8'd0;
        i_pix_col = 9'd3;
        i_mask_bit = 1'b1;
        i_mode = 2'b11;
        i_in_valid = 1'b1;
        @(negedge clk);
        i_in_valid = 1'b0;
        vectors++;
        if ({o_out_valid, o_pixel_out} !== {1'b1, 12'h000}) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_beat: got vld=%b pix=%h expected vld=1 pix=000",
                     o_out_valid, o_pixel_out);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({o_out_valid, o_in_ready, o_pixel_out, o_out_row, o_out_col, o_frame_end} !== 32'd0) begin
            miscompares++;
            $display("[TB] FAIL midframe_reset: got vld=%b rdy=%b pix=%h (%0d,%0d) fe=%b expected all 0",
                     o_out_valid, o_in_ready, o_pixel_out, o_out_row, o_out_col, o_frame_end);
        end
        @(negedge clk);
        rst = 1'b0;
        q_in.delete();
        q_exp.delete();
        add_beat(0, 4, pix_of(0, 4), 1'b0, 2'b00, 1'b0, 12'h000, 1'b0);
        add_beat(0, 0, pix_of(0, 0), 1'b0, 2'b00, 1'b1, pix_of(0, 0), 1'b0);
        add_beat(0, 1, pix_of(0, 1), 1'b0, 2'b00, 1'b1, pix_of(0, 1), 1'b0);
        stream_beats();
        for (int i = 0; i < q_exp.size(); i++) begin
            vectors++;
            if (q_exp[i].valid ? (q_obs[i] !== q_exp[i])
                               : ({q_obs[i].valid, q_obs[i].err} !== {1'b0, q_exp[i].err})) begin
                miscompares++;
                $display("[TB] FAIL post_reset beat %0d: got %h expected %h", i, q_obs[i], q_exp[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass_frame();
        test_fill_frame();
        test_dim();
        test_back_to_back();
        test_sync_error();
        test_mode_change();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
